// File: rtl/pn_period_monitor_pkg.sv
// Shared types and helpers for the PN period monitor: FSM state encoding,
// default widths and the effective-length / mask arithmetic.
package pn_mon_pkg;

   localparam int W_MAX     = 13;
   localparam int CNT_W_DEF = 14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DONE,
      ST_LOCK,
      ST_OVF
   } state_e;

   // Lengths outside 1..w fall back to the full register width w.
   function automatic logic [3:0] eff_len(input logic [3:0] num, input int unsigned w);
      if (num != 4'd0 && 32'(num) <= w) return num;
      return 4'(w);
   endfunction

   function automatic logic [W_MAX-1:0] len_mask(input logic [3:0] n);
      logic [W_MAX:0] m;
      m = ({{W_MAX{1'b0}}, 1'b1} << n) - 1'b1;
      return m[W_MAX-1:0];
   endfunction

endpackage

// File: rtl/pn_period_monitor_if.sv
// Bundle between the PN generator / display path and the period monitor.
// master drives generator state and controls; slave is the monitor.
interface pn_period_monitor_if #(
   parameter int W     = 13,
   parameter int CNT_W = 14
);
   logic             step;
   logic             clr;
   logic [3:0]       num;
   logic [W-1:0]     seq_in;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             lockup;
   logic             overflow;
   logic [CNT_W-1:0] steps;
   logic             busy;
   logic             is_maximal;

   modport master (
      output step, clr, num, seq_in,
      input  period, period_valid, lockup, overflow, steps, busy, is_maximal
   );

   modport slave (
      input  step, clr, num, seq_in,
      output period, period_valid, lockup, overflow, steps, busy, is_maximal
   );
endinterface

// File: rtl/pn_period_monitor_step_edge_detect.sv
// Two-flop synchroniser with rising-edge detect and a one-cycle strobe delay.
// Reusable for any debounced push-button level.
module step_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic strobe_o
);
   logic       sync1_q, sync2_q, prev_q, strobe_q, armed_q;
   logic [1:0] vld_q;
   logic       rise;

   // Edges are only accepted once the synchronised level has been seen low
   // after reset, so a button held through reset release never strobes.
   assign rise = armed_q & sync2_q & ~prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         strobe_q <= 1'b0;
         armed_q  <= 1'b0;
         vld_q    <= 2'b00;
      end else begin
         sync1_q  <= din_i;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         strobe_q <= rise;
         vld_q    <= {vld_q[0], 1'b1};
         armed_q  <= armed_q | (vld_q[1] & ~sync2_q);
      end
   end

   assign strobe_o = strobe_q;
endmodule

// File: rtl/pn_period_monitor.sv
// PN sequence period monitor: counts steps until the captured reference state
// recurs. Optional is_maximal flag built only when MAXLEN_CHECK_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | waiting for the first strobe to capture the reference state
//   ST_COUNT | counting strobes until the reference state recurs
//   ST_DONE  | period measured, outputs held
//   ST_LOCK  | all-zero state seen, outputs held
//   ST_OVF   | counter saturated without a repeat, outputs held
module pn_period_monitor
   import pn_mon_pkg::*;
#(
   parameter int W     = W_MAX,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic               clk,
   input logic               rst,
   pn_period_monitor_if.slave mon_if
);
   logic             strobe;
   state_e           state_q, state_d;
   logic [W-1:0]     ref_q, ref_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             lock_q, lock_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       num_q;
   logic [3:0]       len_n;
   logic [W_MAX-1:0] mask_full;
   logic [W-1:0]     samp;
   logic [CNT_W-1:0] next_cnt;
   logic             restart;

   step_edge_detect u_step (
      .clk      (clk),
      .rst      (rst),
      .din_i    (mon_if.step),
      .strobe_o (strobe)
   );

   assign len_n     = eff_len(mon_if.num, W);
   assign mask_full = len_mask(len_n);
   assign samp      = mon_if.seq_in & mask_full[W-1:0];
   assign next_cnt  = steps_q + CNT_W'(1);
   // A length change invalidates the measurement exactly like clr.
   assign restart   = mon_if.clr | (num_q != mon_if.num);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ref_q    <= '0;
         steps_q  <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         lock_q   <= 1'b0;
         ovf_q    <= 1'b0;
         num_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         steps_q  <= steps_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         lock_q   <= lock_d;
         ovf_q    <= ovf_d;
         num_q    <= mon_if.num;
      end
   end

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      steps_d  = steps_q;
      period_d = period_q;
      valid_d  = valid_q;
      lock_d   = lock_q;
      ovf_d    = ovf_q;
      if (restart) begin
         state_d  = ST_IDLE;
         ref_d    = '0;
         steps_d  = '0;
         period_d = '0;
         valid_d  = 1'b0;
         lock_d   = 1'b0;
         ovf_d    = 1'b0;
      end else if (strobe) begin
         unique case (state_q)
            ST_IDLE: begin
               if (samp == '0) begin
                  lock_d  = 1'b1;
                  state_d = ST_LOCK;
               end else begin
                  ref_d   = samp;
                  steps_d = '0;
                  state_d = ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (samp == '0) begin
                  lock_d  = 1'b1;
                  state_d = ST_LOCK;
               end else if (samp == ref_q) begin
                  period_d = next_cnt;
                  valid_d  = 1'b1;
                  state_d  = ST_DONE;
               end else if (next_cnt == {CNT_W{1'b1}}) begin
                  ovf_d   = 1'b1;
                  steps_d = next_cnt;
                  state_d = ST_OVF;
               end else begin
                  steps_d = next_cnt;
               end
            end
            ST_DONE, ST_LOCK, ST_OVF: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef MAXLEN_CHECK_EN
   logic [CNT_W-1:0] maxlen;
   logic             ismax_q, ismax_d;

   assign maxlen = CNT_W'(({{CNT_W{1'b0}}, 1'b1} << len_n) - 1'b1);

   always_comb begin
      ismax_d = ismax_q;
      if (restart)
         ismax_d = 1'b0;
      else if (state_q == ST_COUNT && state_d == ST_DONE)
         ismax_d = (period_d == maxlen);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ismax_q <= 1'b0;
      else     ismax_q <= ismax_d;
   end

   assign mon_if.is_maximal = ismax_q;
`else
   assign mon_if.is_maximal = 1'b0;
`endif

   assign mon_if.period       = period_q;
   assign mon_if.period_valid = valid_q;
   assign mon_if.lockup       = lock_q;
   assign mon_if.overflow     = ovf_q;
   assign mon_if.steps        = steps_q;
   assign mon_if.busy         = (state_q == ST_COUNT);
endmodule

// File: tb/tb_pn_period_monitor.sv
// Scoreboard bench for pn_period_monitor: two instances (14-bit and 4-bit
// counters) share stimulus; a behavioural model queues expectations.
module tb_pn_period_monitor;
   logic        clk = 1'b0;
   logic        rst;
   logic        step_r, clr_r;
   logic [3:0]  num_r;
   logic [12:0] seq_r;

   always #5 clk = ~clk;

   pn_period_monitor_if #(.W(13), .CNT_W(14)) if_a ();
   pn_period_monitor_if #(.W(13), .CNT_W(4))  if_b ();

   assign if_a.step = step_r;  assign if_b.step = step_r;
   assign if_a.clr  = clr_r;   assign if_b.clr  = clr_r;
   assign if_a.num  = num_r;   assign if_b.num  = num_r;
   assign if_a.seq_in = seq_r; assign if_b.seq_in = seq_r;

   pn_period_monitor #(.W(13), .CNT_W(14)) dut_a (.clk(clk), .rst(rst), .mon_if(if_a));
   pn_period_monitor #(.W(13), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .mon_if(if_b));

   typedef struct {
      int period; int valid; int lockup; int ovf; int steps; int busy; int ismax;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int total = 0;
   int bad   = 0;

   localparam int M_IDLE = 0, M_COUNT = 1, M_DONE = 2, M_LOCK = 3, M_OVF = 4;
   int m_st[2], m_ref[2], m_steps[2], m_per[2], m_val[2], m_lock[2], m_ovf[2], m_max[2];
   int cntw[2] = '{14, 4};
   int m_num;
   int maxseq[16] = '{1, 8, 4, 2, 9, 12, 6, 11, 5, 10, 13, 14, 15, 7, 3, 1};

   function automatic int eff_n(int num);
      return (num >= 1 && num <= 13) ? num : 13;
   endfunction

   task automatic mclear();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = M_IDLE; m_ref[i] = 0; m_steps[i] = 0; m_per[i] = 0;
         m_val[i] = 0; m_lock[i] = 0; m_ovf[i] = 0; m_max[i] = 0;
      end
   endtask

   task automatic msample(int seq);
      int n, s, nxt;
      n = eff_n(m_num);
      s = seq & ((1 << n) - 1);
      for (int i = 0; i < 2; i++) begin
         nxt = m_steps[i] + 1;
         if (m_st[i] == M_IDLE) begin
            if (s == 0) begin m_lock[i] = 1; m_st[i] = M_LOCK; end
            else begin m_ref[i] = s; m_steps[i] = 0; m_st[i] = M_COUNT; end
         end else if (m_st[i] == M_COUNT) begin
            if (s == 0) begin
               m_lock[i] = 1; m_st[i] = M_LOCK;
            end else if (s == m_ref[i]) begin
               m_per[i] = nxt; m_val[i] = 1; m_st[i] = M_DONE;
`ifdef MAXLEN_CHECK_EN
               m_max[i] = (nxt == (1 << n) - 1) ? 1 : 0;
`endif
            end else if (nxt == (1 << cntw[i]) - 1) begin
               m_ovf[i] = 1; m_steps[i] = nxt; m_st[i] = M_OVF;
            end else begin
               m_steps[i] = nxt;
            end
         end
      end
   endtask

   task automatic push();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         e.period = m_per[i]; e.valid = m_val[i]; e.lockup = m_lock[i];
         e.ovf = m_ovf[i]; e.steps = m_steps[i]; e.busy = (m_st[i] == M_COUNT) ? 1 : 0;
         e.ismax = m_max[i];
         if (i == 0) q_a.push_back(e); else q_b.push_back(e);
      end
   endtask

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("a.period", int'(if_a.period), e.period);
            chk("a.valid", int'(if_a.period_valid), e.valid);
            chk("a.lockup", int'(if_a.lockup), e.lockup);
            chk("a.overflow", int'(if_a.overflow), e.ovf);
            chk("a.steps", int'(if_a.steps), e.steps);
            chk("a.busy", int'(if_a.busy), e.busy);
            chk("a.is_maximal", int'(if_a.is_maximal), e.ismax);
         end
         while (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("b.period", int'(if_b.period), e.period);
            chk("b.valid", int'(if_b.period_valid), e.valid);
            chk("b.lockup", int'(if_b.lockup), e.lockup);
            chk("b.overflow", int'(if_b.overflow), e.ovf);
            chk("b.steps", int'(if_b.steps), e.steps);
            chk("b.busy", int'(if_b.busy), e.busy);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: plain step, 1: clr on the strobe edge, 2: num change on the strobe edge
   task automatic do_step(int seq, int mode = 0, int newnum = 0);
      seq_r  = 13'(seq);
      step_r = 1'b1;
      tick(); tick(); tick();
      if (mode == 1) clr_r = 1'b1;
      if (mode == 2) num_r = 4'(newnum);
      step_r = 1'b0;
      tick();
      clr_r = 1'b0;
      repeat (4) tick();
      if (mode == 1) mclear();
      else if (mode == 2 && newnum != m_num) begin mclear(); m_num = newnum; end
      else msample(seq);
      push();
   endtask

   task automatic do_clr();
      clr_r = 1'b1;
      tick();
      clr_r = 1'b0;
      tick();
      mclear();
      push();
   endtask

   task automatic do_num(int n);
      num_r = 4'(n);
      repeat (2) tick();
      if (n != m_num) begin mclear(); m_num = n; end
      push();
   endtask

   task automatic do_reset_held();
      seq_r  = 13'h0005;
      step_r = 1'b1;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      mclear();
      push();
      step_r = 1'b0;
      repeat (6) tick();
   endtask

   initial begin : stim
      int pool[4];
      int len, r;
      rst = 1'b1; step_r = 1'b0; clr_r = 1'b0; num_r = 4'd4; seq_r = '0;
      m_num = 4;
      mclear();
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      push();

      // maximal x^4+x^3+1 sequence
      do_num(4); do_clr();
      for (int i = 0; i < 16; i++) do_step(maxseq[i]);
      do_step(3);

      // masking to 3 bits
      do_num(3); do_clr();
      do_step('h1F05); do_step('h1F06); do_step('h1F07); do_step('h1F05);

      // lock-up: first sample zero, then zero after capture
      do_num(4); do_clr();
      do_step(0); do_step(5);
      do_clr();
      do_step(3); do_step(0);

      // overflow on the 4-bit instance, later samples ignored
      do_num(13); do_clr();
      for (int i = 1; i <= 16; i++) do_step(i);
      do_step(1);
      do_step(2);

      // clr coinciding with the 5th strobe, then a fresh capture
      do_num(4); do_clr();
      for (int i = 0; i < 4; i++) do_step(maxseq[i]);
      do_step(maxseq[4], 1);
      do_step(maxseq[5]);
      do_step(maxseq[6]);

      // num change mid-count, and num change on a strobe edge
      do_num(5);
      do_step(7); do_step(8);
      do_step(9, 2, 6);
      do_step(10);

      // reset mid-count with step held high
      do_step(3); do_step(4);
      do_reset_held();
      do_step(6);
      do_step(7);

      // randomized episodes
      for (int ep = 0; ep < 14; ep++) begin
         for (int j = 0; j < 4; j++) begin
            pool[j] = int'($urandom_range(1, 8191));
            if ($urandom_range(0, 9) == 0) pool[j] = 0;
         end
         do_num(int'($urandom_range(0, 15)));
         do_clr();
         len = int'($urandom_range(3, 24));
         for (int k = 0; k < len; k++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) do_step(pool[$urandom_range(0, 3)], 1);
            else if (r == 1) do_clr();
            else do_step(pool[$urandom_range(0, 3)]);
         end
      end

      repeat (4) tick();
      if (q_a.size() != 0 || q_b.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending a=%0d b=%0d expected 0", q_a.size(), q_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
